// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the accumulator CPU instruction-cycle controller.
package cpu_sequencer_pkg;

    localparam int DEFAULT_WORD_W = 8;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcodes_t;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } seq_state_t;

    // Opcodes whose operand is read from memory into the accumulator path.
    function automatic logic is_aluop(input opcodes_t op);
        logic r;
        r = 1'b0;
        case (op)
            ADD, AND, XOR, LDA: r = 1'b1;
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational state+opcode -> strobe decoder for cpu_sequencer.
module cpu_seq_decode
    import cpu_sequencer_pkg::*;
(
    input  seq_state_t state,
    input  opcodes_t   opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_ir,
    output logic       load_ac,
    output logic       load_pc,
    output logic       inc_pc,
    output logic       halt
);

    logic aluop;

    assign aluop = is_aluop(opcode);

    // Strobe decode; every phase not listed drives all strobes low.
    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        inc_pc  = 1'b0;
        halt    = 1'b0;
        case (state)
            INST_FETCH: mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR:  inc_pc = (opcode != HLT);
            OP_FETCH: mem_rd = aluop;
            ALU_OP: begin
                load_ac = aluop;
                mem_rd  = aluop;
                inc_pc  = (opcode == SKZ) && zero;
                load_pc = (opcode == JMP);
            end
            STORE: begin
                load_ac = aluop;
                mem_rd  = aluop;
                inc_pc  = (opcode == JMP);
                load_pc = (opcode == JMP);
                mem_wr  = (opcode == STO);
            end
            HALTED:   halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller for the 8-bit accumulator CPU.
// Optional macro CPU_SEQ_MEM_WAIT_EN adds a mem_ready input that stretches
// INST_LOAD, OP_FETCH (ALU ops) and STORE (STO) until memory is ready.
//
// state      | meaning
// INST_ADDR  | instruction address on bus, no strobes
// INST_FETCH | read instruction
// INST_LOAD  | read + load IR
// IDLE       | read + load IR (settle)
// OP_ADDR    | bump PC past instruction, or decide HLT
// OP_FETCH   | read operand for ALU ops
// ALU_OP     | accumulator load / SKZ skip / JMP load
// STORE      | write for STO, final JMP load
// HALTED     | absorbing until rst
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int NUM_PHASES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  opcodes_t   opcode,
    input  logic       zero,
`ifdef CPU_SEQ_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_ir,
    output logic       load_ac,
    output logic       load_pc,
    output logic       inc_pc,
    output logic       halt,
    output seq_state_t phase
);

    if (NUM_PHASES != 8) begin : g_bad_phases
        $fatal(1, "cpu_sequencer: NUM_PHASES must be 8");
    end

    seq_state_t state;
    seq_state_t state_next;
    logic       stall;

`ifdef CPU_SEQ_MEM_WAIT_EN
    // Hold only in phases that actually touch memory for this opcode.
    always_comb begin
        stall = 1'b0;
        if (!mem_ready) begin
            case (state)
                INST_LOAD: stall = 1'b1;
                OP_FETCH:  stall = is_aluop(opcode);
                STORE:     stall = (opcode == STO);
                default:   stall = 1'b0;
            endcase
        end
    end
`else
    assign stall = 1'b0;
`endif

    // State register; reset forces INST_ADDR at once so strobes drop immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INST_ADDR;
        else     state <= state_next;
    end

    // Next-state: fixed ring, HLT diverts to HALTED, optional memory stall.
    always_comb begin
        state_next = state;
        case (state)
            INST_ADDR:  state_next = INST_FETCH;
            INST_FETCH: state_next = INST_LOAD;
            INST_LOAD:  state_next = IDLE;
            IDLE:       state_next = OP_ADDR;
            OP_ADDR:    state_next = (opcode == HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   state_next = ALU_OP;
            ALU_OP:     state_next = STORE;
            STORE:      state_next = INST_ADDR;
            HALTED:     state_next = HALTED;
            default:    state_next = INST_ADDR;
        endcase
        if (stall) state_next = state;
    end

    cpu_seq_decode u_decode (
        .state   (state),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .load_ir (load_ir),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .inc_pc  (inc_pc),
        .halt    (halt)
    );

    assign phase = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer (scoreboard of expected phase/strobes).
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

`ifdef CPU_SEQ_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    opcodes_t   opcode = ADD;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt;
    seq_state_t phase;

    typedef struct packed {
        seq_state_t ph;
        logic [6:0] st;   // {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt}
    } exp_t;

    exp_t       sb[$];
    seq_state_t m_state;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
`ifdef CPU_SEQ_MEM_WAIT_EN
        .mem_ready (mem_ready),
`endif
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .load_ir   (load_ir),
        .load_ac   (load_ac),
        .load_pc   (load_pc),
        .inc_pc    (inc_pc),
        .halt      (halt),
        .phase     (phase)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected strobes, written from the per-phase output table.
    function automatic logic [6:0] exp_out(input seq_state_t ph, input opcodes_t op, input logic z);
        logic alu;
        logic rd, wr, ir, ac, pc, inc, h;
        alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        {rd, wr, ir, ac, pc, inc, h} = 7'b0;
        if (ph == INST_FETCH) rd = 1'b1;
        if (ph == INST_LOAD || ph == IDLE) begin rd = 1'b1; ir = 1'b1; end
        if (ph == OP_ADDR) inc = (op != HLT);
        if (ph == OP_FETCH) rd = alu;
        if (ph == ALU_OP) begin ac = alu; rd = alu; inc = (op == SKZ) && z; pc = (op == JMP); end
        if (ph == STORE) begin ac = alu; rd = alu; inc = (op == JMP); pc = (op == JMP); wr = (op == STO); end
        if (ph == HALTED) h = 1'b1;
        return {rd, wr, ir, ac, pc, inc, h};
    endfunction

    function automatic seq_state_t model_next(input seq_state_t ph, input opcodes_t op, input logic rdy);
        logic alu;
        alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        if (WAIT_EN && !rdy &&
            (ph == INST_LOAD || (ph == OP_FETCH && alu) || (ph == STORE && op == STO)))
            return ph;
        if (ph == HALTED) return HALTED;
        if (ph == OP_ADDR && op == HLT) return HALTED;
        if (ph == STORE) return INST_ADDR;
        return seq_state_t'(4'(ph) + 4'd1);
    endfunction

    function automatic logic [7:0] dut_strobes();
        return {1'b0, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt};
    endfunction

    // One clock of stimulus: push expectation, compare, then advance model.
    task automatic cycle(input opcodes_t opc, input logic z, input logic rdy);
        exp_t e;
        opcode = opc;
        zero = z;
        mem_ready = rdy;
        e.ph = m_state;
        e.st = exp_out(m_state, opc, z);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check("phase", 8'(phase), 8'(e.ph));
        check("strobes", dut_strobes(), {1'b0, e.st});
        check("rd_wr_excl", {7'b0, mem_rd & mem_wr}, 8'h00);
        @(posedge clk);
        #1;
        m_state = model_next(m_state, opc, rdy);
    endtask

    // Runs one instruction from INST_ADDR; stall cycles apply in stall_ph.
    task automatic run_instr(input opcodes_t opc, input logic z, input logic z_fetch,
                             input seq_state_t stall_ph, input int stall);
        int n;
        int left;
        logic zz;
        logic rdy;
        n = 0;
        left = stall;
        do begin
            zz = (m_state == OP_FETCH) ? z_fetch : z;
            rdy = 1'b1;
            if (left > 0 && m_state == stall_ph) begin
                rdy = 1'b0;
                left--;
            end
            cycle(opc, zz, rdy);
            n++;
        end while (m_state != INST_ADDR && m_state != HALTED && n < 40);
        check("instr_bound", 8'(n < 40), 8'd1);
    endtask

    task automatic reset_check(input string tag);
        #1;
        check({tag, "_phase"}, 8'(phase), 8'(INST_ADDR));
        check({tag, "_strobes"}, dut_strobes(), 8'h00);
        @(negedge clk);
        check({tag, "_held"}, dut_strobes(), 8'h00);
        rst = 1'b0;
        m_state = INST_ADDR;
    endtask

    initial begin
        // Asynchronous reset mid-cycle at 3 ns.
        #3;
        rst = 1'b1;
        reset_check("rst_initial");

        run_instr(ADD, 1'b0, 1'b0, INST_ADDR, 0);
        run_instr(STO, 1'b0, 1'b0, INST_ADDR, 0);
        run_instr(SKZ, 1'b1, 1'b1, INST_ADDR, 0);
        run_instr(SKZ, 1'b0, 1'b1, INST_ADDR, 0);   // zero pulses only in OP_FETCH
        run_instr(JMP, 1'b0, 1'b0, INST_ADDR, 0);
        run_instr(XOR, 1'b1, 1'b1, INST_ADDR, 0);
        run_instr(AND, 1'b0, 1'b0, INST_ADDR, 0);

        // Reset in the middle of a STO instruction, inside the write phase.
        for (int i = 0; i < 7; i++) cycle(STO, 1'b0, 1'b1);
        check("pre_rst_store", 8'(phase), 8'(STORE));
        #2;
        rst = 1'b1;
        reset_check("rst_mid_store");

        if (WAIT_EN) begin
            run_instr(LDA, 1'b0, 1'b0, OP_FETCH, 3);
            run_instr(STO, 1'b0, 1'b0, STORE, 2);
        end

        run_instr(LDA, 1'b0, 1'b0, INST_ADDR, 0);

        // HLT: halts after OP_ADDR and stays there for any opcode.
        run_instr(HLT, 1'b0, 1'b0, INST_ADDR, 0);
        for (int i = 0; i < 20; i++)
            cycle(opcodes_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
        #2;
        rst = 1'b1;
        reset_check("rst_halted");
        run_instr(ADD, 1'b0, 1'b0, INST_ADDR, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
